// File: rtl/mac_timestep_controller_if.sv
// mac_timestep_controller_if: config, spike, adder, output and status signals of the MAC controller
interface mac_timestep_controller_if #(
  parameter int ADDR_W = 12,
  parameter int W_W    = 32,
  parameter int IDX_W  = 3
);
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_index;
  logic [ADDR_W-1:0] cfg_src_addr;
  logic [W_W-1:0]    cfg_weight;
  logic              cfg_ready;
  logic              spike_valid;
  logic [ADDR_W-1:0] spike_src_addr;
  logic              spike_miss;
  logic              clear;
  logic [W_W-1:0]    adder_a;
  logic [W_W-1:0]    adder_b;
  logic [W_W-1:0]    adder_result;
  logic              out_valid;
  logic              out_ready;
  logic [W_W-1:0]    out_weight;
  logic              busy;
  logic              overrun;
  modport master (
    output cfg_we, cfg_index, cfg_src_addr, cfg_weight, spike_valid, spike_src_addr,
           clear, adder_result, out_ready,
    input  cfg_ready, spike_miss, adder_a, adder_b, out_valid, out_weight, busy, overrun
  );
  modport slave (
    input  cfg_we, cfg_index, cfg_src_addr, cfg_weight, spike_valid, spike_src_addr,
           clear, adder_result, out_ready,
    output cfg_ready, spike_miss, adder_a, adder_b, out_valid, out_weight, busy, overrun
  );
endinterface

// File: rtl/mac_timestep_controller.sv
// mac_timestep_controller: per-neuron synapse table, spike capture and timestep MAC sequencing
module mac_timestep_controller #(
  parameter int N_CONN  = 5,
  parameter int ADDR_W  = 12,
  parameter int W_W     = 32,
  parameter int IDX_W   = 3,
  parameter int ADD_LAT = 1
) (
  input logic clk_i,
  input logic rst_i,
  mac_timestep_controller_if.slave bus
);
  localparam int CNT_W = ADD_LAT > 1 ? $clog2(ADD_LAT) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, ADD_WAIT, OUTPUT} state_e;
  state_e            state_q, state_d;
  logic              valid_q [N_CONN];
  logic [ADDR_W-1:0] addr_q [N_CONN];
  logic [W_W-1:0]    weight_q [N_CONN];
  logic [N_CONN-1:0] incoming_q, incoming_d, work_q, work_d;
  logic [W_W-1:0]    acc_q, acc_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d, miss_q, overrun_q;
  logic              hit, start, has_work;
  logic [IDX_W-1:0]  hit_idx, sel;
  assign bus.cfg_ready  = state_q == IDLE;
  assign bus.busy       = state_q != IDLE;
  assign bus.out_valid  = state_q == OUTPUT;
  assign bus.out_weight = out_q;
  assign bus.adder_a    = a_q;
  assign bus.adder_b    = b_q;
  assign bus.spike_miss = miss_q;
  assign bus.overrun    = overrun_q;
  // Both priority searches run high-to-low so the lowest matching index wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    sel = '0;
    for (int i = N_CONN - 1; i >= 0; i--) begin
      if (valid_q[i] && addr_q[i] == bus.spike_src_addr) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (work_q[i]) sel = IDX_W'(i);
    end
  end
  assign has_work = |work_q;
  assign start = (bus.clear || pending_q) &&
                 (state_q == IDLE || (state_q == OUTPUT && bus.out_ready));
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    out_d = out_q;
    case (state_q)
      IDLE: state_d = start ? SCAN : IDLE;
      SCAN:
        if (has_work) begin
          a_d = acc_q;
          b_d = weight_q[sel];
          work_d[sel] = 1'b0;
          cnt_d = CNT_W'(ADD_LAT - 1);
          state_d = ADD_WAIT;
        end else begin
          out_d = acc_q;
          state_d = OUTPUT;
        end
      ADD_WAIT:
        if (cnt_q == '0) begin
          acc_d = bus.adder_result;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      OUTPUT: state_d = bus.out_ready ? (start ? SCAN : IDLE) : OUTPUT;
      default: state_d = IDLE;
    endcase
    if (start) begin
      work_d = incoming_q;
      acc_d = '0;
    end
  end
  // A spike on the clear edge lands in the freshly emptied incoming bitmap.
  always_comb begin
    incoming_d = start ? '0 : incoming_q;
    if (bus.spike_valid && hit) incoming_d[hit_idx] = 1'b1;
  end
  assign pending_d = start ? 1'b0 : (bus.clear && state_q != IDLE) ? 1'b1 : pending_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      incoming_q <= '0;
      work_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      pending_q <= 1'b0;
      miss_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_CONN; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i] <= '0;
        weight_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      incoming_q <= incoming_d;
      work_q <= work_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      miss_q <= bus.spike_valid && !hit;
      overrun_q <= bus.clear && pending_q && state_q != IDLE;
      if (bus.cfg_we && state_q == IDLE && int'(bus.cfg_index) < N_CONN) begin
        valid_q[bus.cfg_index] <= 1'b1;
        addr_q[bus.cfg_index] <= bus.cfg_src_addr;
        weight_q[bus.cfg_index] <= bus.cfg_weight;
      end
    end
  end
endmodule

// File: tb/tb_mac_timestep_controller.sv
// tb_mac_timestep_controller: directed vectors against a lookup FP32 adder model
module tb_mac_timestep_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errs = 0;
  mac_timestep_controller_if #(.ADDR_W(12), .W_W(32), .IDX_W(3)) bus ();
  mac_timestep_controller #(.N_CONN(5), .ADDR_W(12), .W_W(32), .IDX_W(3), .ADD_LAT(1)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    case ({a, b})
      {32'h3F800000, 32'h3F000000}: return 32'h3FC00000;
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40000000, 32'h3F000000}: return 32'h40200000;
      default: return 32'h7FC00000;
    endcase
  endfunction
  assign bus.adder_result = fadd(bus.adder_a, bus.adder_b);
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [2:0] idx, input logic [11:0] addr, input logic [31:0] w);
    bus.cfg_we = 1'b1;
    bus.cfg_index = idx;
    bus.cfg_src_addr = addr;
    bus.cfg_weight = w;
    step();
    bus.cfg_we = 1'b0;
  endtask
  task automatic spike(input logic [11:0] addr);
    bus.spike_valid = 1'b1;
    bus.spike_src_addr = addr;
    step();
    bus.spike_valid = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
  endtask
  task automatic ts(input string tag, input logic [31:0] exp_w, input int exp_lat,
                    input logic sp, input logic [11:0] sa);
    int n;
    bus.clear = 1'b1;
    bus.spike_valid = sp;
    bus.spike_src_addr = sa;
    step();
    bus.clear = 1'b0;
    bus.spike_valid = 1'b0;
    wait_valid(n);
    chk({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
    chk({tag, "_wt"}, bus.out_weight, exp_w);
    step();
    chk({tag, "_idle"}, {31'b0, bus.busy}, 32'h0);
  endtask
  initial begin
    int n;
    bus.cfg_we = 1'b0;
    bus.cfg_index = '0;
    bus.cfg_src_addr = '0;
    bus.cfg_weight = '0;
    bus.spike_valid = 1'b0;
    bus.spike_src_addr = '0;
    bus.clear = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_cfg_ready", {31'b0, bus.cfg_ready}, 32'h1);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_out_weight", bus.out_weight, 32'h0);
    chk("rst_adder_a", bus.adder_a, 32'h0);
    step();
    rst = 1'b0;
    step();
    cfg(3'd0, 12'h010, 32'h3F800000);
    cfg(3'd1, 12'h020, 32'h40000000);
    cfg(3'd2, 12'h030, 32'h3F000000);
    cfg(3'd6, 12'h040, 32'h12345678);
    spike(12'h040);
    chk("bad_idx_miss", {31'b0, bus.spike_miss}, 32'h1);
    spike(12'h010);
    chk("hit_no_miss", {31'b0, bus.spike_miss}, 32'h0);
    spike(12'h030);
    ts("ac", 32'h3FC00000, 6, 1'b0, 12'h0);
    ts("none", 32'h00000000, 2, 1'b0, 12'h0);
    spike(12'h7FF);
    chk("miss_pulse", {31'b0, bus.spike_miss}, 32'h1);
    step();
    chk("miss_clr", {31'b0, bus.spike_miss}, 32'h0);
    spike(12'h010);
    spike(12'h010);
    ts("dup", 32'h3F800000, 4, 1'b0, 12'h0);
    ts("b_edge", 32'h00000000, 2, 1'b1, 12'h020);
    ts("b_next", 32'h40000000, 4, 1'b0, 12'h0);
    spike(12'h010);
    spike(12'h030);
    bus.out_ready = 1'b0;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    step();
    bus.clear = 1'b1;
    bus.spike_valid = 1'b1;
    bus.spike_src_addr = 12'h020;
    step();
    bus.clear = 1'b0;
    bus.spike_valid = 1'b0;
    chk("ovr_first", {31'b0, bus.overrun}, 32'h0);
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("ovr_pulse", {31'b0, bus.overrun}, 32'h1);
    step();
    chk("ovr_end", {31'b0, bus.overrun}, 32'h0);
    wait_valid(n);
    chk("hold_valid0", {31'b0, bus.out_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {31'b0, bus.out_valid}, 32'h1);
      chk("hold_wt", bus.out_weight, 32'h3FC00000);
    end
    bus.out_ready = 1'b1;
    step();
    chk("direct_busy", {31'b0, bus.busy}, 32'h1);
    chk("direct_nvalid", {31'b0, bus.out_valid}, 32'h0);
    wait_valid(n);
    chk("merged_lat", 32'(n), 32'h3);
    chk("merged_wt", bus.out_weight, 32'h40000000);
    step();
    chk("merged_idle", {31'b0, bus.busy}, 32'h0);
    spike(12'h010);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    step();
    chk("pre_rst_op_b", bus.adder_b, 32'h3F800000);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'h0);
    chk("arst_cfg_ready", {31'b0, bus.cfg_ready}, 32'h1);
    chk("arst_op_b", bus.adder_b, 32'h0);
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    step();
    rst = 1'b0;
    step();
    spike(12'h010);
    chk("arst_table_miss", {31'b0, bus.spike_miss}, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
